alu_j: RTL and testbench
========================

ALU_J -- requirements
Module: alu_j

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset: clk is the single clock, and rst is an asynchronous, active-high reset.
REQ-002 The block SHALL expose the following parameters (name, default, meaning):
- DataWidth, 8, operand/result width.
- NumOpCodeBits, 5, opcode width.
- ParamBits, 8, shift-amount/immediate width.
- NumStatusBits, 6, status width.
REQ-003 The block SHALL expose the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- opcode, in, 5, operation select.
- operand1, in, 8, first operand (A).
- operand2, in, 8, second operand (B).
- param, in, 8, shift amount / immediate.
- result, out, 8, combinational result.
- status, out, 6, combinational flags.
- result_q, out, 8, registered result.
- status_q, out, 6, registered flags.

Function
REQ-004 result and status SHALL be purely combinational from opcode/operand1/operand2/param (zero latency, independent of clk/rst).
REQ-005 status bit map SHALL be:
- [0] overflow (ADD carry-out).
- [1] underflow (SUB borrow).
- [2] zero.
- [3] A==B.
- [4] A>B.
- [5] A<B.
REQ-006 Opcodes and results SHALL be:
- 00000 NOP: result 0.
- 00001 ADD: A+B mod 256.
- 00010 SUB: A-B mod 256.
- 00011 AND: A&B.
- 00100 OR: A|B.
- 00101 NOT: ~B (operand1 ignored).
- 00110 XOR: A^B.
- 00111 SHL: A<<param, logical.
- 01000 SHR: A>>param, logical.
- 01001 VAL: result=param.
- 01010-11111: result 0.
REQ-007 Shifts SHALL use the full 8-bit param as the shift amount; an amount >=8 SHALL yield result 0.
REQ-008 Overflow SHALL be set only for ADD when the 9-bit sum exceeds 255; 0 for all other opcodes.
REQ-009 Underflow SHALL be set only for SUB when A<B (unsigned); 0 for all other opcodes.
REQ-010 Zero flag:
- ADD: SHALL be set only when the full 9-bit sum is 0 (255+1 gives result 0 with zero flag 0).
- SUB, AND, OR, NOT, XOR, SHL, SHR, VAL: SHALL be set when the 8-bit result is 0.
- NOP and undefined opcodes: SHALL be 0.
REQ-011 Compare flags [5:3] (unsigned A vs B) SHALL be computed only for ADD, SUB, AND, OR, XOR, with exactly one of eq/gt/lt set.
REQ-012 For NOT, SHL, SHR, VAL, NOP and undefined opcodes, [5:3] SHALL be 0.
REQ-013 NOP and undefined opcodes SHALL produce result 0 and status 0.
REQ-014 On each rising clk edge, result_q<=result and status_q<=status (1-cycle latency).

Reset
REQ-015 While rst=1, result_q and status_q SHALL be 0 immediately (asynchronous), independent of clk.
REQ-016 rst SHALL NOT affect the combinational result/status outputs.
REQ-017 After rst deasserts, the first rising clk edge SHALL load the current combinational values into result_q/status_q.

Verification
REQ-018 A bench SHALL cover at least these directed scenarios:
- ADD 255+2 -> result 1, status 010001.
- ADD 255+1 -> result 0, status 010001 (zero flag clear).
- ADD 0+0 -> result 0, status 001100.
- SUB 14-15 -> result 255, status 100010.
- SUB 126-126 -> result 0, status 001100.
- AND CC&33 -> result 00, status 010100.
- XOR F0^F0 -> result 0, status 001100.
- NOT A=0F B=FF -> result 0, status 000100.
- NOT B=AC -> result 53, status 0.
- SHL 06 by 3 -> result 30, status 0.
- SHL F6 by 51 -> result 0, status 000100.
- SHR 66 by 4 -> result 06, status 0.
- SHR 76 by 1 -> result 3B, status 0.
- VAL param=0 -> result 0, status 000100.
- Opcode 11111 -> result 0, status 0.
- Registers: apply ADD 1+3 and clock once -> result_q=4, status_q=100000; assert rst mid-cycle -> both 0 before the next edge; deassert rst, then next edge reloads.

Source files
------------

// File: rtl/alu_j.sv
// alu_j: combinational 8-bit ALU with status flags, plus a registered copy of result/status.
module alu_j #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic [DataWidth-1:0]     operand1,
    input  logic [DataWidth-1:0]     operand2,
    input  logic [ParamBits-1:0]     param,
    output logic [DataWidth-1:0]     result,
    output logic [NumStatusBits-1:0] status,
    output logic [DataWidth-1:0]     result_q,
    output logic [NumStatusBits-1:0] status_q
);
    localparam logic [NumOpCodeBits-1:0] OP_ADD = NumOpCodeBits'(1);
    localparam logic [NumOpCodeBits-1:0] OP_SUB = NumOpCodeBits'(2);
    localparam logic [NumOpCodeBits-1:0] OP_AND = NumOpCodeBits'(3);
    localparam logic [NumOpCodeBits-1:0] OP_OR  = NumOpCodeBits'(4);
    localparam logic [NumOpCodeBits-1:0] OP_NOT = NumOpCodeBits'(5);
    localparam logic [NumOpCodeBits-1:0] OP_XOR = NumOpCodeBits'(6);
    localparam logic [NumOpCodeBits-1:0] OP_SHL = NumOpCodeBits'(7);
    localparam logic [NumOpCodeBits-1:0] OP_SHR = NumOpCodeBits'(8);
    localparam logic [NumOpCodeBits-1:0] OP_VAL = NumOpCodeBits'(9);

    logic [DataWidth:0] sum;
    logic               big_shift;
    logic               cmp_en;
    logic               zero;
    logic [5:0]         flags;

    always_comb begin
        sum       = {1'b0, operand1} + {1'b0, operand2};
        big_shift = param >= ParamBits'(DataWidth);
        cmp_en    = opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
                    opcode == OP_OR  || opcode == OP_XOR;
        case (opcode)
            OP_ADD:  result = sum[DataWidth-1:0];
            OP_SUB:  result = operand1 - operand2;
            OP_AND:  result = operand1 & operand2;
            OP_OR:   result = operand1 | operand2;
            OP_NOT:  result = ~operand2;
            OP_XOR:  result = operand1 ^ operand2;
            OP_SHL:  result = big_shift ? '0 : operand1 << param;
            OP_SHR:  result = big_shift ? '0 : operand1 >> param;
            OP_VAL:  result = DataWidth'(param);
            default: result = '0;
        endcase
        // ADD judges zero on the 9-bit sum, so a wrap to 0 with carry is not zero
        zero  = opcode == OP_ADD ? sum == '0 :
                (opcode >= OP_SUB && opcode <= OP_VAL) ? result == '0 : 1'b0;
        flags = {cmp_en && operand1 < operand2,
                 cmp_en && operand1 > operand2,
                 cmp_en && operand1 == operand2,
                 zero,
                 opcode == OP_SUB && operand1 < operand2,
                 opcode == OP_ADD && sum[DataWidth]};
        status = NumStatusBits'(flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            status_q <= '0;
        end else begin
            result_q <= result;
            status_q <= status;
        end
    end
endmodule

// File: tb/tb_alu_j.sv
// tb_alu_j: directed vector table, randomized model comparison and register/reset sequences for alu_j.
module tb_alu_j;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = '0;
    logic [7:0] operand1 = '0, operand2 = '0, param = '0;
    logic [7:0] result, result_q;
    logic [5:0] status, status_q;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        logic [5:0] s;
    } vec_t;

    vec_t vecs[15];

    alu_j dut (
        .clk(clk), .rst(rst), .opcode(opcode), .operand1(operand1),
        .operand2(operand2), .param(param), .result(result), .status(status),
        .result_q(result_q), .status_q(status_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference built from arithmetic on integers rather than bit logic
    function automatic void model(input logic [4:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] p,
                                  output logic [7:0] r, output logic [5:0] s);
        int ia = int'(a), ib = int'(b), ip = int'(p), full = 0, res = 0;
        bit of = 0, uf = 0, z = 0, cmp = 0;
        case (op)
            5'd1: begin full = ia + ib; res = full % 256; of = full > 255; cmp = 1; end
            5'd2: begin res = (ia - ib + 256) % 256; uf = ia < ib; cmp = 1; end
            5'd3: begin res = int'(a & b); cmp = 1; end
            5'd4: begin res = int'(a | b); cmp = 1; end
            5'd5: res = 255 - ib;
            5'd6: begin res = int'(a ^ b); cmp = 1; end
            5'd7: res = ip >= 8 ? 0 : (ia * (1 << ip)) % 256;
            5'd8: res = ip >= 8 ? 0 : ia / (1 << ip);
            5'd9: res = ip;
            default: res = 0;
        endcase
        z = op == 5'd1 ? full == 0 : (op >= 5'd2 && op <= 5'd9) ? res == 0 : 0;
        r = 8'(res);
        s = {cmp && ia < ib, cmp && ia > ib, cmp && ia == ib, z, uf, of};
    endfunction

    task automatic drive(input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] p);
        opcode = op; operand1 = a; operand2 = b; param = p;
    endtask

    initial begin
        logic [7:0] er;
        logic [5:0] es;
        vecs[0]  = '{5'd1,  8'hFF, 8'h02, 8'h00, 8'h01, 6'b010001};
        vecs[1]  = '{5'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 6'b010001};
        vecs[2]  = '{5'd1,  8'h00, 8'h00, 8'h00, 8'h00, 6'b001100};
        vecs[3]  = '{5'd2,  8'd14, 8'd15, 8'h00, 8'hFF, 6'b100010};
        vecs[4]  = '{5'd2,  8'd126,8'd126,8'h00, 8'h00, 6'b001100};
        vecs[5]  = '{5'd3,  8'hCC, 8'h33, 8'h00, 8'h00, 6'b010100};
        vecs[6]  = '{5'd6,  8'hF0, 8'hF0, 8'h00, 8'h00, 6'b001100};
        vecs[7]  = '{5'd5,  8'h0F, 8'hFF, 8'h00, 8'h00, 6'b000100};
        vecs[8]  = '{5'd5,  8'h00, 8'hAC, 8'h00, 8'h53, 6'b000000};
        vecs[9]  = '{5'd7,  8'h06, 8'h00, 8'h03, 8'h30, 6'b000000};
        vecs[10] = '{5'd7,  8'hF6, 8'h00, 8'h51, 8'h00, 6'b000100};
        vecs[11] = '{5'd8,  8'h66, 8'h00, 8'h04, 8'h06, 6'b000000};
        vecs[12] = '{5'd8,  8'h76, 8'h00, 8'h01, 8'h3B, 6'b000000};
        vecs[13] = '{5'd9,  8'h12, 8'h34, 8'h00, 8'h00, 6'b000100};
        vecs[14] = '{5'd31, 8'h55, 8'h55, 8'h07, 8'h00, 6'b000000};

        // reset holds the registers at 0 even across a clock edge
        #1;
        chk("reset result_q", int'(result_q), 0);
        chk("reset status_q", int'(status_q), 0);
        drive(5'd1, 8'd1, 8'd3, 8'd0);
        @(posedge clk); #1;
        chk("reset hold result_q", int'(result_q), 0);
        chk("comb under reset", int'(result), 4);
        @(negedge clk); rst = 1'b0;

        // register load, async reset mid-cycle, reload after release
        @(posedge clk); #1;
        chk("reg add result_q", int'(result_q), 4);
        chk("reg add status_q", int'(status_q), 6'b100000);
        #2 rst = 1'b1;
        #1;
        chk("async rst result_q", int'(result_q), 0);
        chk("async rst status_q", int'(status_q), 0);
        chk("rst comb result", int'(result), 4);
        chk("rst comb status", int'(status), 6'b100000);
        @(negedge clk); rst = 1'b0; #1;
        chk("post rst hold", int'(result_q), 0);
        @(posedge clk); #1;
        chk("reload result_q", int'(result_q), 4);
        chk("reload status_q", int'(status_q), 6'b100000);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p);
            #1;
            chk($sformatf("vec%0d result", i), int'(result), int'(vecs[i].r));
            chk($sformatf("vec%0d status", i), int'(status), int'(vecs[i].s));
            @(posedge clk); #1;
            chk($sformatf("vec%0d result_q", i), int'(result_q), int'(vecs[i].r));
            chk($sformatf("vec%0d status_q", i), int'(status_q), int'(vecs[i].s));
        end

        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [7:0] a, b, p;
            op = 5'($urandom_range(0, 31));
            if (i % 3 == 0) op = 5'($urandom_range(1, 9));
            a = 8'($urandom);
            b = (i % 7 == 0) ? a : 8'($urandom);
            p = (i % 2 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            @(negedge clk);
            drive(op, a, b, p);
            model(op, a, b, p, er, es);
            #1;
            chk($sformatf("rand%0d op%0d result", i, op), int'(result), int'(er));
            chk($sformatf("rand%0d op%0d status", i, op), int'(status), int'(es));
            @(posedge clk); #1;
            chk($sformatf("rand%0d result_q", i), int'(result_q), int'(er));
            chk($sformatf("rand%0d status_q", i), int'(status_q), int'(es));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
